// File: rtl/snake_steer.sv
// Snake head steering: button edge intake, 2-deep direction queue, tick-paced movement.
// Define SNAKE_WRAP_EN to wrap at the playfield edges instead of flagging a wall hit.
module snake_steer #(
  parameter int unsigned TICK_PERIOD = 6000000,
  parameter int unsigned COORD_W     = 8,
  parameter int unsigned GRID_W      = 160,
  parameter int unsigned GRID_H      = 120,
  parameter int unsigned START_X     = 64,
  parameter int unsigned START_Y     = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               game_over,
  input  logic               pause,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic [3:0]         dir,
  output logic               step_tick,
  output logic               wall_hit
);

  localparam int unsigned        CntW   = $clog2(TICK_PERIOD);
  localparam logic [CntW-1:0]    CntMax = CntW'(TICK_PERIOD - 1);
  localparam logic [COORD_W-1:0] XMax   = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] YMax   = COORD_W'(GRID_H - 1);

  logic [CntW-1:0]     cnt_q;
  logic [3:0]          btn_q;
  logic [1:0][3:0]     fifo_q, fifo_d;
  logic [1:0]          fill_q, fill_d, fill_mid;
  logic [3:0]          btn_now, rise, req, ref_dir, rev_ref, step_dir;
  logic                run, step, pop, push, edge_hit;
  logic [COORD_W-1:0]  nx, ny;

  // Button bits share the dir one-hot layout: {down, up, left, right}.
  always_comb begin
    btn_now = {btn_down, btn_up, btn_left, btn_right};
    rise    = btn_now & ~btn_q;
    req     = 4'b0000;
    if (rise[1])      req = 4'b0010;
    else if (rise[0]) req = 4'b0001;
    else if (rise[2]) req = 4'b0100;
    else if (rise[3]) req = 4'b1000;

    if (fill_q == 2'd2)      ref_dir = fifo_q[1];
    else if (fill_q == 2'd1) ref_dir = fifo_q[0];
    else                     ref_dir = dir;
    rev_ref = {ref_dir[2], ref_dir[3], ref_dir[0], ref_dir[1]};

    push = !game_over && (req != 4'b0000) && (req != ref_dir) && (req != rev_ref)
           && (fill_q != 2'd2);
    run  = !pause && !game_over && !wall_hit;
    step = run && (cnt_q == CntMax);
    pop  = step && (fill_q != 2'd0);
    step_dir = pop ? fifo_q[0] : dir;

    // Pop shifts first, then the push lands behind whatever remains.
    fifo_d   = fifo_q;
    fill_mid = fill_q - {1'b0, pop};
    if (pop) fifo_d[0] = fifo_q[1];
    fill_d = fill_mid;
    if (push) begin
      fifo_d[fill_mid[0]] = req;
      fill_d              = fill_mid + 2'd1;
    end
  end

  always_comb begin
    nx       = head_x;
    ny       = head_y;
    edge_hit = 1'b0;
    unique case (step_dir)
      4'b0001: begin
        if (head_x == XMax) begin nx = '0; edge_hit = 1'b1; end
        else nx = head_x + 1'b1;
      end
      4'b0010: begin
        if (head_x == '0) begin nx = XMax; edge_hit = 1'b1; end
        else nx = head_x - 1'b1;
      end
      4'b0100: begin
        if (head_y == '0) begin ny = YMax; edge_hit = 1'b1; end
        else ny = head_y - 1'b1;
      end
      4'b1000: begin
        if (head_y == YMax) begin ny = '0; edge_hit = 1'b1; end
        else ny = head_y + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      btn_q     <= '0;
      fifo_q    <= '0;
      fill_q    <= '0;
      head_x    <= COORD_W'(START_X);
      head_y    <= COORD_W'(START_Y);
      dir       <= 4'b0001;
      step_tick <= 1'b0;
      wall_hit  <= 1'b0;
    end else begin
      btn_q     <= btn_now;
      fifo_q    <= fifo_d;
      fill_q    <= fill_d;
      step_tick <= step;
      if (run) cnt_q <= (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
      if (step) begin
        dir <= step_dir;
`ifdef SNAKE_WRAP_EN
        head_x <= nx;
        head_y <= ny;
`else
        if (edge_hit) begin
          wall_hit <= 1'b1;
        end else begin
          head_x <= nx;
          head_y <= ny;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_snake_steer.sv
// Bench for snake_steer: directed scenarios with literal expectations, then randomized
// stimulus compared every cycle against a queue-based behavioural model.
module tb_snake_steer;
  localparam int TP = 4, GW = 8, GH = 8, SX = 4, SY = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic bl = 1'b0, br = 1'b0, bu = 1'b0, bd = 1'b0, go = 1'b0, pz = 1'b0;
  logic [7:0] hx, hy;
  logic [3:0] dir;
  logic       tick, wall;

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  snake_steer #(
    .TICK_PERIOD(TP), .COORD_W(8), .GRID_W(GW), .GRID_H(GH), .START_X(SX), .START_Y(SY)
  ) dut (
    .clk(clk), .rst(rst), .btn_left(bl), .btn_right(br), .btn_up(bu), .btn_down(bd),
    .game_over(go), .pause(pz), .head_x(hx), .head_y(hy), .dir(dir), .step_tick(tick),
    .wall_hit(wall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: direction as 0 right, 1 left, 2 up, 3 down; reverse is d^1.
  int m_x, m_y, m_d, m_cnt, req, refd, nd, tx, ty;
  bit m_wall, m_tick, run, step, push, pl, pr, pu, pd;
  int q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_x = SX; m_y = SY; m_d = 0; m_cnt = 0; m_wall = 0; m_tick = 0;
      q.delete();
      pl = 0; pr = 0; pu = 0; pd = 0;
    end else begin
      run  = !pz && !go && !m_wall;
      step = run && (m_cnt == TP - 1);
      req  = -1;
      if (bl && !pl)      req = 1;
      else if (br && !pr) req = 0;
      else if (bu && !pu) req = 2;
      else if (bd && !pd) req = 3;
      refd = (q.size() > 0) ? q[q.size()-1] : m_d;
      push = !go && req >= 0 && req != refd && req != (refd ^ 1) && q.size() < 2;
      m_tick = step;
      if (step) begin
        if (q.size() > 0) nd = q.pop_front();
        else nd = m_d;
        tx = m_x; ty = m_y;
        case (nd)
          0: tx = tx + 1;
          1: tx = tx - 1;
          2: ty = ty - 1;
          default: ty = ty + 1;
        endcase
`ifdef SNAKE_WRAP_EN
        m_x = (tx + GW) % GW;
        m_y = (ty + GH) % GH;
`else
        if (tx < 0 || tx >= GW || ty < 0 || ty >= GH) m_wall = 1;
        else begin m_x = tx; m_y = ty; end
`endif
        m_d = nd;
      end
      if (push) q.push_back(req);
      if (run) m_cnt = (m_cnt + 1) % TP;
      pl = bl; pr = br; pu = bu; pd = bd;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (chk_en)
      check("model", {10'd0, hx, hy, dir, tick, wall},
            {10'd0, 8'(m_x), 8'(m_y), 4'(1 << m_d), m_tick, m_wall});
  end

  task automatic wait_step(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!tick && n < 40);
    if (!tick) check("step_timeout", {31'd0, tick}, 32'd1);
  endtask

  // Called at a negedge; returns at the following negedge with the button released.
  task automatic pulse(input int b);
    case (b)
      0: br = 1'b1;
      1: bl = 1'b1;
      2: bu = 1'b1;
      default: bd = 1'b1;
    endcase
    @(negedge clk);
    bl = 1'b0; br = 1'b0; bu = 1'b0; bd = 1'b0;
  endtask

  int n, ticks;

  initial begin
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_x", hx, 4);
    check("rst_y", hy, 4);
    check("rst_dir", dir, 4'b0001);
    check("rst_tick", tick, 0);
    check("rst_wall", wall, 0);
    rst = 1'b0;

    wait_step(n);
    check("first_latency", n, TP);
    check("step1_x", hx, 5);
    @(negedge clk); pulse(1);               // reverse of right: dropped
    wait_step(n);
    check("rev_drop_x", hx, 6);
    check("rev_drop_dir", dir, 4'b0001);

    @(negedge clk); pulse(2); pulse(1);     // up then left
    wait_step(n);
    check("up_xy", {hx, hy}, {8'd6, 8'd3});
    check("up_dir", dir, 4'b0100);
    wait_step(n);
    check("left_xy", {hx, hy}, {8'd5, 8'd3});
    check("left_dir", dir, 4'b0010);

    @(negedge clk); pulse(2); pulse(0); pulse(3);  // down overflows the queue
    wait_step(n);
    check("q1_xy", {hx, hy}, {8'd5, 8'd2});
    wait_step(n);
    check("q2_xy", {hx, hy}, {8'd6, 8'd2});
    check("q2_dir", dir, 4'b0001);
    wait_step(n);
    check("q3_xy", {hx, hy}, {8'd7, 8'd2});
    check("q3_dir", dir, 4'b0001);
    wait_step(n);
`ifdef SNAKE_WRAP_EN
    check("wrap_x", hx, 0);
    check("wrap_wall", wall, 0);
`else
    check("wall_x", hx, 7);
    check("wall_flag", wall, 1);
    ticks = 0;
    repeat (12) begin @(posedge clk); #1; ticks += int'(tick); end
    check("wall_no_steps", ticks, 0);
`endif

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    wait_step(n);
    check("post_rst_latency", n, TP);
    @(negedge clk); pz = 1'b1;
    repeat (10) @(negedge clk);
    pz = 1'b0;
    wait_step(n);
    check("pause_remaining", n, TP);
    check("pause_x", hx, 6);

    @(negedge clk); go = 1'b1;
    pulse(2);
    ticks = 0;
    repeat (12) begin @(posedge clk); #1; ticks += int'(tick); end
    check("gameover_no_steps", ticks, 0);
    @(negedge clk); go = 1'b0;
    wait_step(n);
    check("gameover_x", hx, 7);
    check("gameover_dir", dir, 4'b0001);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      bl  = ($urandom % 6) == 0;
      br  = ($urandom % 6) == 0;
      bu  = ($urandom % 6) == 0;
      bd  = ($urandom % 6) == 0;
      pz  = ($urandom % 12) == 0;
      if (($urandom % 80) == 0) go = ~go;
      rst = (($urandom % 150) == 0) || (wall && ($urandom % 10) == 0);
    end
    @(negedge clk);
    bl = 0; br = 0; bu = 0; bd = 0; pz = 0; go = 0; rst = 0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snake_steer.md
SNAKE_STEER -- requirements
Module: snake_steer

Interface
REQ-001 The block SHALL have parameter TICK_PERIOD, default 6000000, clocks per movement step (>=2).
REQ-002 The block SHALL have parameter COORD_W, default 8, coordinate width in bits.
REQ-003 The block SHALL have parameters GRID_W and GRID_H, defaults 160 and 120, playfield size in cells (<=2^COORD_W).
REQ-004 The block SHALL have parameters START_X and START_Y, defaults 64 and 64, head position after reset.
REQ-005 The block SHALL have port clk, input, 1, sole clock; all logic is on its rising edge with no derived clocks.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have ports btn_left, btn_right, btn_up, btn_down, input, 1 each, level button inputs already synchronised to clk.
REQ-008 The block SHALL have port game_over, input, 1; high freezes intake and movement.
REQ-009 The block SHALL have port pause, input, 1; high holds the tick counter.
REQ-010 The block SHALL have ports head_x and head_y, output, COORD_W each, registered head cell.
REQ-011 The block SHALL have port dir, output, 4, current heading, one-hot: right 0001, left 0010, up 0100, down 1000.
REQ-012 The block SHALL have port step_tick, output, 1, one-cycle pulse coincident with each head update.
REQ-013 The block SHALL have port wall_hit, output, 1, sticky wall-collision flag.

Function
REQ-014 Tick counter SHALL count 0..TICK_PERIOD-1 while pause=0, game_over=0 and wall_hit=0, hold otherwise, and wrap to 0 after TICK_PERIOD-1.
REQ-015 A step SHALL occur at the edge where the counter wraps; at that edge step_tick<=1 and head_x, head_y, dir update together; step_tick SHALL be 0 in all other cycles.
REQ-016 Each button SHALL be rising-edge detected against a registered copy; a held button SHALL produce exactly one request.
REQ-017 Simultaneous rising edges SHALL resolve with priority left > right > up > down; lower-priority requests that cycle are discarded.
REQ-018 Requests SHALL enter a 2-entry direction FIFO, and only when game_over=0.
REQ-019 A request SHALL be dropped if equal to, or the reverse of, the reference direction (last FIFO entry if non-empty, else dir).
REQ-020 A request arriving with the FIFO full SHALL be dropped; FIFO contents are unchanged.
REQ-021 On a step with the FIFO non-empty, the oldest entry SHALL pop into dir and the move SHALL use the new dir in that same step.
REQ-022 Push and pop in the same cycle SHALL both take effect; the reference direction for the push is evaluated before the pop.
REQ-023 Each step SHALL move exactly one cell: right x+1, left x-1, up y-1, down y+1.
REQ-024 Arithmetic SHALL be bounded by GRID_W/GRID_H, never by natural COORD_W overflow.

Reset
REQ-025 On rst: head_x=START_X, head_y=START_Y, dir=0001, step_tick=0, wall_hit=0, counter=0, FIFO empty, edge registers 0.
REQ-026 rst asserted mid-step or mid-push SHALL discard the pending operation; the first step after release SHALL occur TICK_PERIOD clocks later.

Configuration
REQ-027 With SNAKE_WRAP_EN defined, moves past an edge SHALL wrap (x=GRID_W-1 right -> 0; x=0 left -> GRID_W-1; same for y with GRID_H) and wall_hit SHALL stay 0.
REQ-028 Without SNAKE_WRAP_EN, a step whose target lies outside the grid SHALL leave head unchanged, update dir, pulse step_tick, set wall_hit=1, and suppress all further steps until rst.

Verification (TICK_PERIOD=4, GRID_W=GRID_H=8, START 4,4)
REQ-029 Release rst, no buttons -> step_tick every 4 clocks; head_x 5,6,7; dir=0001.
REQ-030 Pulse btn_up then btn_left within one tick -> next step head (x,3) dir=0100; following step (x-1,3) dir=0010.
REQ-031 Press btn_left while dir=0001, FIFO empty -> dropped; head_x keeps incrementing.
REQ-032 Three valid requests (up, left, down) before one step -> down dropped (full); steps follow up then left.
REQ-033 Head at x=7 moving right: with SNAKE_WRAP_EN -> head_x=0; without -> head_x stays 7, wall_hit=1, no further step_tick.
REQ-034 Assert pause for 10 clocks mid-count -> step delayed exactly 10 clocks; game_over=1 -> no steps, button requests ignored.
